// File: rtl/pc_unit_if.sv
//------------------------------------------------------------------------------
// Module : pc_unit_if
// Brief  : Fetch-PC control/redirect bundle between the pipeline and pc_unit.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pc_unit_if #(
    parameter int W = 32
);
    logic         stall;
    logic         exc;
    logic         br_taken;
    logic [W-1:0] br_target;
    logic         jmp;
    logic [W-1:0] jmp_target;
    logic [W-1:0] pcf;
    logic [W-1:0] pcplus;
    logic [W-1:0] epc;
    logic         misalign;
    logic         pend;

    modport master (
        output stall, exc, br_taken, br_target, jmp, jmp_target,
        input  pcf, pcplus, epc, misalign, pend
    );

    modport slave (
        input  stall, exc, br_taken, br_target, jmp, jmp_target,
        output pcf, pcplus, epc, misalign, pend
    );
endinterface

`default_nettype wire

// File: rtl/pc_unit.sv
//------------------------------------------------------------------------------
// Module : pc_unit
// Brief  : Fetch PC with reset vector, stall, held redirects and alignment trap.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_unit #(
    parameter int          W         = 32,
    parameter logic [W-1:0] RESET_VEC = '0,
    parameter logic [W-1:0] TRAP_VEC  = W'('h80),
    parameter int          STEP      = 4,
    parameter int          ALIGN     = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pc_unit_if.slave      bus
);
    localparam logic [W-1:0] C_STEP       = W'(STEP);
    localparam logic [W-1:0] C_ALIGN_MASK = W'((1 << ALIGN) - 1);

    logic [W-1:0] pcf_q, pcf_d;
    logic [W-1:0] epc_q, epc_d;
    logic [W-1:0] pend_tgt_q, pend_tgt_d;
    logic         pend_q, pend_d;
    logic         misalign_q, misalign_d;

    logic         w_req;
    logic [W-1:0] w_req_tgt;
    logic [W-1:0] w_load_tgt;

    // Branch outranks jump when both are presented in the same cycle.
    assign w_req     = bus.br_taken | bus.jmp;
    assign w_req_tgt = bus.br_taken ? bus.br_target : bus.jmp_target;
    assign w_load_tgt = w_req ? w_req_tgt : pend_tgt_q;

    always_comb begin
        pcf_d      = pcf_q;
        epc_d      = epc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        misalign_d = 1'b0;

        if (bus.exc) begin
            pcf_d  = TRAP_VEC;
            epc_d  = pcf_q;
            pend_d = 1'b0;
        end else if (bus.stall) begin
            if (w_req) begin
                pend_d     = 1'b1;
                pend_tgt_d = w_req_tgt;
            end
        end else if (w_req || pend_q) begin
            // A fresh request on the release cycle supersedes the held target.
            pend_d = 1'b0;
            if ((w_load_tgt & C_ALIGN_MASK) != '0) begin
                pcf_d      = TRAP_VEC;
                epc_d      = w_load_tgt;
                misalign_d = 1'b1;
            end else begin
                pcf_d = w_load_tgt;
            end
        end else begin
            pcf_d = pcf_q + C_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q      <= RESET_VEC;
            epc_q      <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            epc_q      <= epc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pcf      = pcf_q;
    assign bus.pcplus   = pcf_q + C_STEP;
    assign bus.epc      = epc_q;
    assign bus.misalign = misalign_q;
    assign bus.pend     = pend_q;

endmodule

`default_nettype wire
